counter_seq_ctrl: RTL and testbench

Command-driven controller that sequences a WIDTH-bit up-counter as a programmable timer. It accepts START/STOP/PAUSE/RESUME commands over a valid/ready handshake and runs the counter from 0 to a programmed limit. It runs in one-shot or auto-reload mode and pulses done at each terminal count. It sits between a control/CSR agent and the counter datapath, replacing free-running count behaviour with gated, bounded sequencing.

---
 rtl/counter_seq_pkg.sv | 30 +++
 rtl/counter_seq_ctrl_if.sv | 40 ++++
 rtl/counter_datapath.sv | 35 +++
 rtl/counter_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencing controller.
//   - command opcodes carried on cmd_op
//   - controller state enum (also exported on the debug port)
//   - decode record produced each cycle by the controller
package counter_seq_pkg;

  localparam logic [1:0] OP_START  = 2'd0;
  localparam logic [1:0] OP_STOP   = 2'd1;
  localparam logic [1:0] OP_PAUSE  = 2'd2;
  localparam logic [1:0] OP_RESUME = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  // One cycle's worth of controller decisions, derived from the current
  // state, the accepted command (if any) and the datapath terminal flag.
  typedef struct packed {
    state_t nxt_state;
    logic   load_cfg;   // capture cmd_limit / cmd_reload
    logic   dp_clear;   // count <= 0 because of STOP / START
    logic   dp_zero;    // count <= 0 because of an auto-reload wrap
    logic   dp_enable;  // count <= count + 1
    logic   set_done;
    logic   set_err;
  } ctrl_dec_t;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Command channel between a control/CSR agent (master) and the counter
// sequencing controller (slave).
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_op, cmd_limit and cmd_reload are only looked
// at in that transfer cycle. The slave drops cmd_ready for exactly one cycle
// after each transfer, then raises it again; the master may hold cmd_valid
// high across that gap.
//
// Signals:
//   cmd_valid  master -> slave  command present
//   cmd_ready  slave  -> master command can be taken this cycle
//   cmd_op     master -> slave  0=START 1=STOP 2=PAUSE 3=RESUME
//   cmd_limit  master -> slave  terminal count (START only)
//   cmd_reload master -> slave  1=auto-reload, 0=one-shot (START only)
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_limit;
  logic             cmd_reload;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_limit,
    output cmd_reload,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_limit,
    input  cmd_reload,
    output cmd_ready
  );
endinterface

// File: rtl/counter_datapath.sv
// WIDTH-bit up-counter used by the sequencing controller.
//
// Ports:
//   clk        clock, posedge
//   reset      synchronous, active-high; count <= 0
//   clear      count <= 0 (restart / stop)
//   load_zero  count <= 0 (auto-reload wrap)
//   enable     count <= count + 1 (modulo 2^WIDTH)
//   limit      terminal value to compare against
//   count      registered count
//   at_limit   count == limit
module counter_datapath #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load_zero,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  always_ff @(posedge clk) begin
    if (reset || clear || load_zero) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign at_limit = (count == limit);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command-driven timer controller. Accepts START/STOP/PAUSE/RESUME over a
// valid/ready channel and sequences a WIDTH-bit counter from 0 up to a
// programmed limit, either once (one-shot) or repeatedly (auto-reload),
// pulsing done at every terminal count.
//
// Ports:
//   clk        clock, posedge
//   reset      synchronous, active-high
//   cmd        command channel (slave side), see counter_seq_ctrl_if
//   count      current count (registered)
//   busy       high in RUN or PAUSED
//   paused     high in PAUSED
//   done       one-cycle pulse at terminal count
//   cmd_err    one-cycle pulse when an accepted command is illegal (ignored)
//   state_dbg  current controller state
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  counter_seq_ctrl_if.slave  cmd,
  output logic [WIDTH-1:0]   count,
  output logic               busy,
  output logic               paused,
  output logic               done,
  output logic               cmd_err,
  output state_t             state_dbg
);

  state_t           state;
  logic [WIDTH-1:0] limit_q;
  logic             reload_q;
  logic             ready_q;
  logic             at_limit;
  logic             accept;
  ctrl_dec_t        dec;

  assign accept        = cmd.cmd_valid && ready_q;
  assign cmd.cmd_ready = ready_q;
  assign state_dbg     = state;

  counter_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .reset     (reset),
    .clear     (dec.dp_clear),
    .load_zero (dec.dp_zero),
    .enable    (dec.dp_enable),
    .limit     (limit_q),
    .count     (count),
    .at_limit  (at_limit)
  );

  // Next-state / datapath decode. STOP and START win over everything,
  // including a terminal count in the same cycle.
  always_comb begin
    dec           = '0;
    dec.nxt_state = state;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_START: begin
              dec.load_cfg  = 1'b1;
              dec.dp_clear  = 1'b1;
              dec.nxt_state = ST_RUN;
            end
            OP_STOP:  dec.dp_clear = 1'b1;
            default:  dec.set_err  = 1'b1;
          endcase
        end
      end

      ST_RUN: begin
        if (accept && cmd.cmd_op == OP_STOP) begin
          dec.dp_clear  = 1'b1;
          dec.nxt_state = ST_IDLE;
        end else if (accept && cmd.cmd_op == OP_START) begin
          dec.load_cfg  = 1'b1;
          dec.dp_clear  = 1'b1;
          dec.nxt_state = ST_RUN;
        end else begin
          // No command, PAUSE, or (illegal) RESUME: the terminal count is
          // processed normally; RESUME only adds the error pulse.
          dec.set_err = accept && (cmd.cmd_op == OP_RESUME);
          if (at_limit) begin
            dec.set_done = 1'b1;
            if (reload_q) begin
              dec.dp_zero = 1'b1;
              if (accept && cmd.cmd_op == OP_PAUSE) begin
                dec.nxt_state = ST_PAUSED;
              end
            end else begin
              // One-shot: count holds at the limit and the run ends,
              // whether or not a PAUSE arrived with it.
              dec.nxt_state = ST_IDLE;
            end
          end else if (accept && cmd.cmd_op == OP_PAUSE) begin
            dec.nxt_state = ST_PAUSED;
          end else begin
            dec.dp_enable = 1'b1;
          end
        end
      end

      ST_PAUSED: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_START: begin
              dec.load_cfg  = 1'b1;
              dec.dp_clear  = 1'b1;
              dec.nxt_state = ST_RUN;
            end
            OP_STOP: begin
              dec.dp_clear  = 1'b1;
              dec.nxt_state = ST_IDLE;
            end
            // Count holds on the resume edge; increments start next edge.
            OP_RESUME: dec.nxt_state = ST_RUN;
            default:   dec.set_err   = 1'b1;
          endcase
        end
      end

      default: begin
        dec.dp_clear  = 1'b1;
        dec.nxt_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      limit_q  <= '0;
      reload_q <= 1'b0;
      ready_q  <= 1'b1;
      done     <= 1'b0;
      cmd_err  <= 1'b0;
      busy     <= 1'b0;
      paused   <= 1'b0;
    end else begin
      state   <= dec.nxt_state;
      ready_q <= !accept;
      done    <= dec.set_done;
      cmd_err <= dec.set_err;
      busy    <= (dec.nxt_state != ST_IDLE);
      paused  <= (dec.nxt_state == ST_PAUSED);
      if (dec.load_cfg) begin
        limit_q  <= cmd.cmd_limit;
        reload_q <= cmd.cmd_reload;
      end
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
module tb_counter_seq_ctrl;
  import counter_seq_pkg::*;

  localparam int W = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN = 1;
  localparam int M_PAUSED = 2;

  logic clk;
  logic reset;
  logic [W-1:0] count;
  logic busy, paused, done, cmd_err;
  state_t state_dbg;

  int checks = 0;
  int errors = 0;

  // reference model
  int m_st, m_cnt, m_lim;
  bit m_rl, m_rdy, m_done, m_err;

  counter_seq_ctrl_if #(.WIDTH(W)) bus ();

  counter_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd       (bus.slave),
    .count     (count),
    .busy      (busy),
    .paused    (paused),
    .done      (done),
    .cmd_err   (cmd_err),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         v;
    logic [1:0] op;
    logic [3:0] lim;
    bit         rl;
    int         e_cnt;
    bit         e_busy;
    bit         e_paused;
    bit         e_done;
    bit         e_err;
    bit         e_rdy;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_cnt = 0; m_lim = 0; m_rl = 0;
    m_rdy = 1; m_done = 0; m_err = 0;
  endtask

  // Rule-level model: one call per clock edge with the inputs present at it.
  task automatic model_step(input bit v, input logic [1:0] op,
                            input logic [3:0] lim, input bit rl);
    bit acc;
    bit term;
    acc = v && m_rdy;
    m_done = 0;
    m_err = 0;
    m_rdy = !acc;
    term = (m_st == M_RUN) && (m_cnt == m_lim);
    if (acc && op == 2'd1) begin
      m_cnt = 0; m_st = M_IDLE;
    end else if (acc && op == 2'd0) begin
      m_lim = int'(lim); m_rl = rl; m_cnt = 0; m_st = M_RUN;
    end else if (acc && m_st != M_RUN) begin
      if (op == 2'd3 && m_st == M_PAUSED) m_st = M_RUN;
      else m_err = 1;
    end else if (m_st == M_RUN) begin
      m_err = acc && (op == 2'd3);
      if (term) begin
        m_done = 1;
        if (m_rl) m_cnt = 0;
        else m_st = M_IDLE;
        if (acc && op == 2'd2) m_st = m_rl ? M_PAUSED : M_IDLE;
      end else if (acc && op == 2'd2) begin
        m_st = M_PAUSED;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    state_t es;
    es = (m_st == M_RUN) ? ST_RUN : (m_st == M_PAUSED) ? ST_PAUSED : ST_IDLE;
    chk({tag, ".count"}, int'(count), m_cnt);
    chk({tag, ".busy"}, int'(busy), int'(m_st != M_IDLE));
    chk({tag, ".paused"}, int'(paused), int'(m_st == M_PAUSED));
    chk({tag, ".done"}, int'(done), int'(m_done));
    chk({tag, ".cmd_err"}, int'(cmd_err), int'(m_err));
    chk({tag, ".cmd_ready"}, int'(bus.cmd_ready), int'(m_rdy));
    chk({tag, ".state"}, int'(state_dbg), int'(es));
  endtask

  // driver: apply inputs for one clock, advance model, sample #1 after edge
  task automatic cycle(input string tag, input bit v, input logic [1:0] op,
                       input logic [3:0] lim, input bit rl);
    bus.cmd_valid = v;
    bus.cmd_op = op;
    bus.cmd_limit = lim;
    bus.cmd_reload = rl;
    @(posedge clk);
    model_step(v, op, lim, rl);
    #1;
    compare_model(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 2'd0, 4'd0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'd0;
    bus.cmd_limit = 4'd9;
    bus.cmd_reload = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    chk({tag, ".count"}, int'(count), 0);
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".paused"}, int'(paused), 0);
    chk({tag, ".done"}, int'(done), 0);
    chk({tag, ".cmd_err"}, int'(cmd_err), 0);
    chk({tag, ".cmd_ready"}, int'(bus.cmd_ready), 1);
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    int pulses;
    int rdy_low;

    vecs[0] = '{1, 2'd0, 4'd3, 0, 0, 1, 0, 0, 0, 0};
    vecs[1] = '{0, 2'd0, 4'd0, 0, 1, 1, 0, 0, 0, 1};
    vecs[2] = '{0, 2'd0, 4'd0, 0, 2, 1, 0, 0, 0, 1};
    vecs[3] = '{0, 2'd0, 4'd0, 0, 3, 1, 0, 0, 0, 1};
    vecs[4] = '{0, 2'd0, 4'd0, 0, 3, 0, 0, 1, 0, 1};
    vecs[5] = '{0, 2'd0, 4'd0, 0, 3, 0, 0, 0, 0, 1};
    vecs[6] = '{1, 2'd3, 4'd0, 0, 3, 0, 0, 0, 1, 0};
    vecs[7] = '{0, 2'd0, 4'd0, 0, 3, 0, 0, 0, 0, 1};
    vecs[8] = '{1, 2'd1, 4'd0, 0, 0, 0, 0, 0, 0, 0};
    vecs[9] = '{0, 2'd0, 4'd0, 0, 0, 0, 0, 0, 0, 1};

    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'd0;
    bus.cmd_limit = '0;
    bus.cmd_reload = 1'b0;
    repeat (2) @(posedge clk);
    do_reset("reset");

    // table: one-shot limit=3, RESUME in IDLE, STOP in IDLE
    foreach (vecs[i]) begin
      cycle("tbl_model", vecs[i].v, vecs[i].op, vecs[i].lim, vecs[i].rl);
      chk($sformatf("tbl%0d.count", i), int'(count), vecs[i].e_cnt);
      chk($sformatf("tbl%0d.busy", i), int'(busy), int'(vecs[i].e_busy));
      chk($sformatf("tbl%0d.paused", i), int'(paused), int'(vecs[i].e_paused));
      chk($sformatf("tbl%0d.done", i), int'(done), int'(vecs[i].e_done));
      chk($sformatf("tbl%0d.err", i), int'(cmd_err), int'(vecs[i].e_err));
      chk($sformatf("tbl%0d.ready", i), int'(bus.cmd_ready), int'(vecs[i].e_rdy));
    end

    // auto-reload limit=2: 3 done pulses in 9 cycles, ready low once
    pulses = 0;
    rdy_low = 0;
    cycle("reload", 1'b1, 2'd0, 4'd2, 1'b1);
    if (!bus.cmd_ready) rdy_low++;
    for (int i = 0; i < 9; i++) begin
      cycle("reload", 1'b0, 2'd0, 4'd0, 1'b0);
      chk("reload.seq", int'(count), (i + 1) % 3);
      if (done) pulses++;
      if (!bus.cmd_ready) rdy_low++;
    end
    chk("reload.pulses", pulses, 3);
    chk("reload.ready_low", rdy_low, 1);
    cycle("reload_stop", 1'b1, 2'd1, 4'd0, 1'b0);
    idle("gap", 1);

    // PAUSE at count=2, hold 4 cycles, RESUME, finish one-shot
    cycle("pause", 1'b1, 2'd0, 4'd5, 1'b0);
    idle("pause", 2);
    chk("pause.pre", int'(count), 2);
    cycle("pause", 1'b1, 2'd2, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle("pause.hold", 1'b0, 2'd0, 4'd0, 1'b0);
      chk("pause.hold_cnt", int'(count), 2);
      chk("pause.hold_flag", int'(paused), 1);
    end
    cycle("resume", 1'b1, 2'd3, 4'd0, 1'b0);
    chk("resume.cnt", int'(count), 2);
    for (int i = 3; i <= 5; i++) begin
      cycle("resume.run", 1'b0, 2'd0, 4'd0, 1'b0);
      chk("resume.seq", int'(count), i);
    end
    cycle("resume.term", 1'b0, 2'd0, 4'd0, 1'b0);
    chk("resume.done", int'(done), 1);
    chk("resume.busy", int'(busy), 0);

    // STOP exactly at terminal (reload): no done, count 0, IDLE
    cycle("stopterm", 1'b1, 2'd0, 4'd4, 1'b1);
    idle("stopterm", 4);
    chk("stopterm.pre", int'(count), 4);
    cycle("stopterm", 1'b1, 2'd1, 4'd0, 1'b0);
    chk("stopterm.done", int'(done), 0);
    chk("stopterm.cnt", int'(count), 0);
    chk("stopterm.busy", int'(busy), 0);
    idle("gap", 1);

    // PAUSE exactly at terminal (reload): done, count 0, PAUSED
    cycle("pauseterm", 1'b1, 2'd0, 4'd4, 1'b1);
    idle("pauseterm", 4);
    cycle("pauseterm", 1'b1, 2'd2, 4'd0, 1'b0);
    chk("pauseterm.done", int'(done), 1);
    chk("pauseterm.cnt", int'(count), 0);
    chk("pauseterm.paused", int'(paused), 1);
    chk("pauseterm.err", int'(cmd_err), 0);
    idle("gap", 1);

    // PAUSE while PAUSED: single error pulse, nothing else moves
    cycle("pp", 1'b1, 2'd2, 4'd0, 1'b0);
    chk("pp.err", int'(cmd_err), 1);
    chk("pp.paused", int'(paused), 1);
    chk("pp.cnt", int'(count), 0);
    cycle("pp2", 1'b0, 2'd0, 4'd0, 1'b0);
    chk("pp2.err", int'(cmd_err), 0);
    cycle("pp_stop", 1'b1, 2'd1, 4'd0, 1'b0);
    idle("gap", 1);

    // reset in the middle of a run with a command pending
    cycle("rstrun", 1'b1, 2'd0, 4'd5, 1'b0);
    idle("rstrun", 3);
    chk("rstrun.pre", int'(count), 3);
    do_reset("rstrun");
    idle("rstrun.after", 2);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset("rnd_reset");
      end else begin
        cycle("rnd", ($urandom_range(0, 3) == 0),
              2'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                          : 4'($urandom_range(0, 5)),
              1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
